// File: rtl/serial_pair_serializer_msb_first.sv
// -----------------------------------------------------------------------------
// serial_pair_serializer_msb_first
//
// Feeds the MSB-first serial comparator. It accepts an operand pair (in_a,
// in_b) in parallel over a valid/ready handshake. It then shifts out one bit
// pair per clock, MSB first, with word framing so the comparator can restart
// on each MSB and be sampled on each LSB. Words stream back-to-back: a new
// pair is accepted on the LSB cycle of the current word, so there is no
// bubble between words.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair on in_a/in_b is valid
//   in_ready   block can take a pair this cycle (combinational)
//   in_a/in_b  WIDTH-bit parallel operands
//   out_valid  out_a/out_b carry a bit pair this cycle
//   out_a/b    current operand bits, MSB first
//   out_first  cycle carrying bit WIDTH-1
//   out_last   cycle carrying bit 0
//
// Downstream hookup: comparator reset = rst | (out_valid & out_first). The
// comparator result is valid on the out_last cycle.
// -----------------------------------------------------------------------------
module serial_pair_serializer_msb_first #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // Index of the bit pair currently shown on the outputs.
  logic [CW-1:0]    cnt_q, cnt_d;

  logic out_valid_q, out_valid_d;
  logic out_a_q,     out_a_d;
  logic out_b_q,     out_b_d;
  logic out_first_q, out_first_d;
  logic out_last_q,  out_last_d;

  logic accept;

  // Ready on the LSB cycle as well as when idle. This lets the next word's MSB
  // follow directly. For WIDTH=1 every output cycle is an LSB, so ready stays
  // high and the block takes one word per clock.
  assign in_ready = ~rst & ((state_q == IDLE) | out_last_q);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_a_d     = 1'b0;
    out_b_d     = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;

    if (accept) begin
      // The MSB goes straight to the output register. The shifters keep the
      // remaining bits, aligned so that the next bit sits at WIDTH-1.
      state_d     = SHIFT;
      out_valid_d = 1'b1;
      out_a_d     = in_a[WIDTH-1];
      out_b_d     = in_b[WIDTH-1];
      out_first_d = 1'b1;
      out_last_d  = (WIDTH == 1);
      sa_d        = in_a << 1;
      sb_d        = in_b << 1;
      cnt_d       = CW'(WIDTH - 1);
    end else if (state_q == SHIFT && !out_last_q) begin
      out_valid_d = 1'b1;
      out_a_d     = sa_q[WIDTH-1];
      out_b_d     = sb_q[WIDTH-1];
      out_last_d  = (cnt_q == CW'(1));
      sa_d        = sa_q << 1;
      sb_d        = sb_q << 1;
      cnt_d       = cnt_q - CW'(1);
    end else if (state_q == SHIFT) begin
      // The LSB went out with no follow-on word. Return to idle with the
      // outputs zeroed. The counter is never decremented past 0.
      state_d = IDLE;
      sa_d    = '0;
      sb_d    = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= 1'b0;
      out_b_q     <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/serial_pair_serializer_msb_first.md
Name: serial_pair_serializer_msb_first

Overview:
Upstream feeder for the MSB-first serial comparator. It accepts two WIDTH-bit operands in parallel through a valid/ready handshake and shifts them out one bit pair per clock, most significant bit first. It also emits word framing (out_first, out_last), so the downstream comparator can be re-initialised on each word's MSB and its result sampled on the LSB. Back-to-back words stream with no idle cycle between them.

Parameters:
WIDTH, 8, operand width in bits; legal range 1..32.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair on in_a/in_b is valid.
in_ready  output  1  block can accept a pair this cycle.
in_a  input  WIDTH  operand A, parallel.
in_b  input  WIDTH  operand B, parallel.
out_valid  output  1  out_a/out_b carry a valid bit pair this cycle.
out_a  output  1  current bit of A, MSB first.
out_b  output  1  current bit of B, MSB first.
out_first  output  1  high on the cycle carrying bit WIDTH-1 (MSB).
out_last  output  1  high on the cycle carrying bit 0 (LSB).

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: out_valid, out_a, out_b, out_first and out_last are all 0. Shift registers and bit counter are cleared. State is IDLE.
- in_ready is combinational: ~rst & (state==IDLE | out_last). It is 0 while rst is high. It does not depend on in_valid.
- Accept: a transfer occurs on a rising edge where in_valid & in_ready. in_a/in_b are captured into shift registers sa/sb, and the counter is loaded with WIDTH-1.
- Latency: the MSB pair appears on out_a/out_b with out_valid=1 and out_first=1 in the cycle immediately after the accept edge. All outputs are registered.
- States:
  - IDLE: out_valid=0. On accept, go to SHIFT.
  - SHIFT: each cycle present sa[WIDTH-1]/sb[WIDTH-1], shift left by one, decrement the counter. When the counter is 0 (out_last=1): on accept, reload and stay in SHIFT (next cycle is the new MSB, out_first=1); otherwise go to IDLE.
- No output backpressure: the downstream stage consumes one pair every out_valid cycle.
- out_a, out_b, out_first and out_last are 0 whenever out_valid=0.
- Exactly WIDTH consecutive out_valid cycles per word. out_first and out_last each assert exactly once per word.
- WIDTH=1: out_first and out_last are both high on the single output cycle. in_ready stays 1 continuously, so one word per clock.
- in_valid high while in_ready=0: no capture. The in-flight word is unaffected. The upstream source holds its data (standard valid/ready; in_valid must not drop before transfer).
- Reset mid-word: the in-flight word is discarded. Outputs are 0 from the cycle after the rst edge. No partial word resumes after rst deasserts.
- Reset and in_valid in the same cycle: reset wins and nothing is captured.
- Counter width is $clog2(WIDTH) with a minimum of 1. It never wraps below 0.
- Integration: downstream comparator reset = rst | (out_valid & out_first), applied so prior-state registers start fresh on each MSB. The comparison result is valid on the out_last cycle.

Test Plan:
- WIDTH=8, single word: in_a=8'hA5, in_b=8'hA4, accepted at cycle 0. Required: cycles 1..8 give out_a = 1,0,1,0,0,1,0,1 and out_b = 1,0,1,0,0,1,0,0. out_first only at cycle 1, out_last only at cycle 8, out_valid=0 at cycle 9. Chained comparator reports a_greater_b=1 at cycle 8.
- Back-to-back: in_valid held high with words (8'h0F, 8'hF0) then (8'h33, 8'h33). Required: second word's MSB at cycle 9 with out_first=1, no gap. in_ready=1 only at cycles 0 and 8. Comparator gives a_less_b=1 at cycle 8 and a_eq_b=1 at cycle 16.
- Stall while busy: in_valid asserted at cycle 3 during a word. Required: no capture until cycle 8 (in_ready=1), the in-flight bits are unchanged, and the new MSB appears at cycle 9.
- Reset mid-word: rst high for one cycle at cycle 4 of a word. Required: all outputs 0 from cycle 5, in_ready=0 during rst and 1 the cycle after, and the next accepted word streams correctly from its MSB.
- WIDTH=1: in_valid held high with in_a/in_b = (1,0), (0,1), (1,1). Required: one output per cycle, out_first=out_last=1 each cycle, and in_ready held at 1.
- Random regression: 1000 random pairs with random in_valid gaps, WIDTH=8 and WIDTH=5. The scoreboard reconstructs each word from the serial bits and checks it, plus exactly one out_first and one out_last per word.
